// File: rtl/addr4u_bist_ctrl.sv
// BIST controller for 4-bit unsigned adders: sweeps all 256 {a,b} pairs,
// checks each result against a golden a+b and reports the mismatch statistics.
`timescale 1ns/1ps
module addr4u_bist_ctrl #(
    parameter int DUT_LAT = 0,
    parameter int ERR_W   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [3:0]       dut_a,
    output logic [3:0]       dut_b,
    input  logic [4:0]       dut_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       first_fail_vec,
    output logic             first_fail_valid
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t     state;
    logic [7:0] vec;
    logic [1:0] drain_cnt;
    logic       vec_valid;
    logic       flush;
    logic       cmp_vld;
    logic [7:0] cmp_tag;
    logic [4:0] golden;
    logic       miss;

    assign dut_a     = vec[7:4];
    assign dut_b     = vec[3:0];
    assign vec_valid = (state == RUN);
    assign flush     = abort && (state == RUN || state == DRAIN);

    // The vector tag travels through the delay line; golden is rebuilt from
    // the tag at the compare point, which is equivalent to delaying the sum.
    generate
        if (DUT_LAT == 0) begin : g_nodly
            assign cmp_vld = vec_valid;
            assign cmp_tag = vec;
        end else begin : g_dly
            logic [DUT_LAT-1:0] vld_sr;
            logic [7:0]         tag_sr [DUT_LAT];

            // NOTE: the delay line is reset as well, so a stale tag can never
            // produce a compare after reset or abort.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_sr <= '0;
                    for (int i = 0; i < DUT_LAT; i++) tag_sr[i] <= '0;
                end else if (flush) begin
                    vld_sr <= '0;
                    for (int i = 0; i < DUT_LAT; i++) tag_sr[i] <= '0;
                end else begin
                    vld_sr[0] <= vec_valid;
                    tag_sr[0] <= vec;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        vld_sr[i] <= vld_sr[i-1];
                        tag_sr[i] <= tag_sr[i-1];
                    end
                end
            end

            assign cmp_vld = vld_sr[DUT_LAT-1];
            assign cmp_tag = tag_sr[DUT_LAT-1];
        end
    endgenerate

    assign golden = {1'b0, cmp_tag[7:4]} + {1'b0, cmp_tag[3:0]};
    assign miss   = cmp_vld && (dut_o != golden);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            vec              <= '0;
            drain_cnt        <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking last-assignment-wins lets the abort branch
            // below override this compare update within the same edge.
            if (miss) begin
                err_count <= err_count + ERR_W'(1);
                if (!first_fail_valid) begin
                    first_fail_vec   <= cmp_tag;
                    first_fail_valid <= 1'b1;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start && !abort) begin
                        state            <= RUN;
                        vec              <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end

                RUN: begin
                    if (vec == 8'hFF) begin
                        vec <= '0;
                        if (DUT_LAT > 0) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == '0) && !miss;
                        end
                    end else begin
                        vec <= vec + 8'd1;
                    end
                end

                DRAIN: begin
                    if (drain_cnt == 2'(DUT_LAT - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !miss;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end

                default: state <= IDLE;
            endcase

            if (flush) begin
                state            <= IDLE;
                vec              <= '0;
                drain_cnt        <= '0;
                busy             <= 1'b0;
                done             <= 1'b0;
                pass             <= 1'b0;
                err_count        <= '0;
                first_fail_vec   <= '0;
                first_fail_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_addr4u_bist_ctrl.sv
// Self-checking bench for addr4u_bist_ctrl: behavioural adder models with
// injectable faults drive a DUT_LAT=0 and a DUT_LAT=2 controller instance.
`timescale 1ns/1ps
module tb_addr4u_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       st0, ab0, st1, ab1;
    logic [3:0] a0, b0, a1, b1;
    logic [4:0] o0, o1;
    logic       busy0, done0, pass0, ffvld0;
    logic       busy1, done1, pass1, ffvld1;
    logic [8:0] err0, err1;
    logic [7:0] ffv0, ffv1;

    int n_pass  = 0;
    int n_total = 0;

    // Fault model applied to the behavioural adder
    int         fault_kind;   // 0 none, 1 stuck-at-0, 2 stuck-at-1, 3 random corruption
    logic [2:0] fault_bit;
    logic [4:0] corrupt [256];
    logic       lat0_src;     // 1: instance 0 sees a 2-stage registered adder
    logic [4:0] p0_1, p0_2, p1_1, p1_2;

    function automatic logic [4:0] model_o(input logic [7:0] v);
        logic [4:0] s;
        s = 5'(v[7:4]) + 5'(v[3:0]);
        case (fault_kind)
            1: s[fault_bit] = 1'b0;
            2: s[fault_bit] = 1'b1;
            3: s = s ^ corrupt[v];
            default: ;
        endcase
        return s;
    endfunction

    always @(posedge clk) begin
        p0_1 <= model_o({a0, b0});
        p0_2 <= p0_1;
        p1_1 <= model_o({a1, b1});
        p1_2 <= p1_1;
    end

    always_comb begin
        o0 = lat0_src ? p0_2 : model_o({a0, b0});
        o1 = p1_2;
    end

    addr4u_bist_ctrl #(.DUT_LAT(0), .ERR_W(9)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .abort(ab0),
        .dut_a(a0), .dut_b(b0), .dut_o(o0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffv0), .first_fail_valid(ffvld0)
    );

    addr4u_bist_ctrl #(.DUT_LAT(2), .ERR_W(9)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .abort(ab1),
        .dut_a(a1), .dut_b(b1), .dut_o(o1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffv1), .first_fail_valid(ffvld1)
    );

    // Reference: enumerate all pairs and compare the model against plain a+b
    task automatic ref_sweep(output int e, output logic [7:0] ff, output logic ffv);
        e = 0; ff = 8'h00; ffv = 1'b0;
        for (int v = 0; v < 256; v++) begin
            if (model_o(8'(v)) !== 5'(v / 16 + v % 16)) begin
                e++;
                if (!ffv) begin ffv = 1'b1; ff = 8'(v); end
            end
        end
    endtask

    // Launch a sweep on instance 0; optionally re-pulse start or abort at cycle n
    task automatic run_sweep0(input int poke_at, input int abort_at,
                              output int cycles, output int seq_bad);
        int n;
        n = 0; seq_bad = 0;
        @(negedge clk); st0 = 1'b1;
        @(negedge clk); st0 = 1'b0;
        while (!done0 && n < 600) begin
            if (n < 256 && ({a0, b0} !== 8'(n) || busy0 !== 1'b1)) seq_bad++;
            if (n == abort_at) begin
                ab0 = 1'b1;
                @(negedge clk); ab0 = 1'b0;
                cycles = n;
                return;
            end
            st0 = (n == poke_at);
            @(negedge clk); n++;
        end
        st0 = 1'b0;
        cycles = n;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; st0 = 0; ab0 = 0; st1 = 0; ab1 = 0;
        fault_kind = 0; fault_bit = 0; lat0_src = 0;
        for (int v = 0; v < 256; v++) corrupt[v] = '0;
        #12;
        n_total++;
        if ({busy0, done0, pass0, err0, ffv0, ffvld0, a0, b0} !== '0)
            $display("FAIL reset0: got %h expected 0", {busy0, done0, pass0, err0, ffv0, ffvld0, a0, b0});
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({busy1, done1, pass1, err1, ffv1, ffvld1, a1, b1} !== '0)
            $display("FAIL reset1: got %h expected 0", {busy1, done1, pass1, err1, ffv1, ffvld1, a1, b1});
        else n_pass++;
    endtask

    task automatic test_clean();
        int c, sb;
        fault_kind = 0;
        run_sweep0(-1, -1, c, sb);
        n_total++; if (c !== 256) $display("FAIL clean_cycles: got %0d expected 256", c); else n_pass++;
        n_total++; if (sb !== 0) $display("FAIL clean_vec_seq: got %0d bad cycles expected 0", sb); else n_pass++;
        n_total++; if (err0 !== 9'd0) $display("FAIL clean_err: got %0d expected 0", err0); else n_pass++;
        n_total++; if ({pass0, ffvld0, busy0} !== 3'b100)
            $display("FAIL clean_flags: got pass/ffvld/busy=%b expected 100", {pass0, ffvld0, busy0}); else n_pass++;
    endtask

    task automatic test_stuck_faults();
        int c, sb;
        fault_kind = 1; fault_bit = 3'd4;
        run_sweep0(-1, -1, c, sb);
        n_total++; if (err0 !== 9'd120) $display("FAIL o4sa0_err: got %0d expected 120", err0); else n_pass++;
        n_total++; if ({ffvld0, ffv0} !== {1'b1, 8'h1F})
            $display("FAIL o4sa0_first: got %b/%h expected 1/1f", ffvld0, ffv0); else n_pass++;
        n_total++; if (pass0 !== 1'b0) $display("FAIL o4sa0_pass: got %b expected 0", pass0); else n_pass++;
        fault_kind = 2; fault_bit = 3'd0;
        run_sweep0(-1, -1, c, sb);
        n_total++; if (err0 !== 9'd128) $display("FAIL o0sa1_err: got %0d expected 128", err0); else n_pass++;
        n_total++; if ({ffvld0, ffv0} !== {1'b1, 8'h00})
            $display("FAIL o0sa1_first: got %b/%h expected 1/00", ffvld0, ffv0); else n_pass++;
    endtask

    task automatic test_random_faults();
        int c, sb, e, poke;
        logic [7:0] ff;
        logic ffv;
        for (int it = 0; it < 6; it++) begin
            fault_kind = int'($urandom_range(1, 3));
            fault_bit  = 3'($urandom_range(0, 4));
            for (int v = 0; v < 256; v++)
                corrupt[v] = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            poke = int'($urandom_range(1, 250));
            ref_sweep(e, ff, ffv);
            run_sweep0(poke, -1, c, sb);
            n_total++; if (c !== 256 || sb !== 0)
                $display("FAIL rand%0d_timing: got %0d cycles %0d bad expected 256/0", it, c, sb); else n_pass++;
            n_total++; if (err0 !== 9'(e)) $display("FAIL rand%0d_err: got %0d expected %0d", it, err0, e); else n_pass++;
            n_total++; if ({ffvld0, ffv0, pass0} !== {ffv, ff, (e == 0)})
                $display("FAIL rand%0d_first: got %b/%h/%b expected %b/%h/%b", it, ffvld0, ffv0, pass0, ffv, ff, (e == 0));
            else n_pass++;
        end
    endtask

    task automatic test_done_restart();
        int c, sb, n;
        fault_kind = 1; fault_bit = 3'd4;
        run_sweep0(-1, -1, c, sb);
        @(negedge clk); ab0 = 1'b1;
        @(negedge clk); ab0 = 1'b0;
        n_total++; if ({done0, err0} !== {1'b1, 9'd120})
            $display("FAIL abort_in_done: got done=%b err=%0d expected 1/120", done0, err0); else n_pass++;
        st0 = 1'b1; ab0 = 1'b1;
        @(negedge clk); st0 = 1'b0; ab0 = 1'b0;
        n_total++; if ({done0, busy0} !== 2'b10)
            $display("FAIL start_abort_together: got done/busy=%b expected 10", {done0, busy0}); else n_pass++;
        fault_kind = 0;
        st0 = 1'b1;
        @(negedge clk); st0 = 1'b0;
        n_total++; if ({done0, busy0, err0, ffvld0} !== {2'b01, 9'd0, 1'b0})
            $display("FAIL restart_from_done: got done=%b busy=%b err=%0d ffvld=%b expected 0/1/0/0",
                     done0, busy0, err0, ffvld0); else n_pass++;
        n = 0;
        while (!done0 && n < 600) begin @(negedge clk); n++; end
        n_total++; if ({n == 256, err0, pass0} !== {1'b1, 9'd0, 1'b1})
            $display("FAIL restart_sweep: got cycles=%0d err=%0d pass=%b expected 256/0/1", n, err0, pass0); else n_pass++;
    endtask

    task automatic test_abort();
        int c, sb;
        fault_kind = 2; fault_bit = 3'd0;
        run_sweep0(-1, 100, c, sb);
        n_total++; if ({busy0, done0, pass0, err0, ffvld0, a0, b0} !== '0)
            $display("FAIL abort_state: got busy=%b done=%b pass=%b err=%0d ffvld=%b ab=%h expected all 0",
                     busy0, done0, pass0, err0, ffvld0, {a0, b0}); else n_pass++;
        n_total++; if (c !== 100 || sb !== 0) $display("FAIL abort_point: got %0d/%0d expected 100/0", c, sb); else n_pass++;
        fault_kind = 1; fault_bit = 3'd4;
        run_sweep0(-1, -1, c, sb);
        n_total++; if ({c == 256, err0, ffv0} !== {1'b1, 9'd120, 8'h1F})
            $display("FAIL abort_resweep: got cycles=%0d err=%0d first=%h expected 256/120/1f", c, err0, ffv0); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int c, sb;
        fault_kind = 2; fault_bit = 3'd0;
        @(negedge clk); st0 = 1'b1;
        @(negedge clk); st0 = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++; if ({busy0, done0, pass0, err0, ffv0, ffvld0, a0, b0} !== '0)
            $display("FAIL reset_mid_run: got busy=%b err=%0d ffvld=%b ab=%h expected 0",
                     busy0, err0, ffvld0, {a0, b0}); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (busy0 !== 1'b0) $display("FAIL reset_stays_idle: got busy=%b expected 0", busy0); else n_pass++;
        fault_kind = 0;
        run_sweep0(-1, -1, c, sb);
        n_total++; if ({c == 256, sb == 0, err0, pass0} !== {2'b11, 9'd0, 1'b1})
            $display("FAIL reset_resweep: got cycles=%0d bad=%0d err=%0d pass=%b expected 256/0/0/1", c, sb, err0, pass0);
        else n_pass++;
    endtask

    task automatic test_latency2();
        int n;
        for (int pass_i = 0; pass_i < 2; pass_i++) begin
            fault_kind = (pass_i == 0) ? 0 : 1;
            fault_bit  = 3'd4;
            repeat (3) @(negedge clk);
            st1 = 1'b1;
            @(negedge clk); st1 = 1'b0;
            n = 0;
            while (!done1 && n < 600) begin @(negedge clk); n++; end
            n_total++; if (n !== 258) $display("FAIL lat2_cycles%0d: got %0d expected 258", pass_i, n); else n_pass++;
            if (pass_i == 0) begin
                n_total++; if ({err1, pass1, ffvld1} !== {9'd0, 2'b10})
                    $display("FAIL lat2_clean: got err=%0d pass=%b ffvld=%b expected 0/1/0", err1, pass1, ffvld1);
                else n_pass++;
            end else begin
                n_total++; if ({err1, ffvld1, ffv1, pass1} !== {9'd120, 1'b1, 8'h1F, 1'b0})
                    $display("FAIL lat2_o4sa0: got err=%0d ffvld=%b first=%h pass=%b expected 120/1/1f/0",
                             err1, ffvld1, ffv1, pass1);
                else n_pass++;
            end
        end
    endtask

    task automatic test_lat_mismatch();
        int c, sb;
        fault_kind = 0; lat0_src = 1'b1;
        repeat (3) @(negedge clk);
        run_sweep0(-1, -1, c, sb);
        n_total++; if (!(err0 > 9'd0) || pass0 !== 1'b0)
            $display("FAIL lat_mismatch: got err=%0d pass=%b expected err>0 pass=0", err0, pass0); else n_pass++;
        lat0_src = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_stuck_faults();
        test_random_faults();
        test_done_restart();
        test_abort();
        test_reset_mid_run();
        test_latency2();
        test_lat_mismatch();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/addr4u_bist_ctrl.md
Name: addr4u_bist_ctrl

Overview:
- Built-in self-test controller for the 4-bit unsigned adder family (addr4u_*). It sits at the other end of the adder interface.
- Generates all 256 operand pairs on A[3:0]/B[3:0] and samples the 5-bit result O[4:0].
- Compares each result against an internal golden A+B, then reports mismatch count, pass/fail and the first failing vector.
- Used to measure fault observability of evolved adder netlists under injected faults.

Parameters:
- DUT_LAT, 0: DUT output latency in cycles (0 = purely combinational DUT); legal range 0..3.
- ERR_W, 9: width of the mismatch counter; must hold 256.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled in IDLE or DONE only.
- abort  input  1  cancel a sweep; returns to IDLE.
- dut_a  output  4  operand A to DUT (A[3:0]).
- dut_b  output  4  operand B to DUT (B[3:0]).
- dut_o  input  5  DUT result O[4:0].
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE.
- pass  output  1  high in DONE when err_count==0.
- err_count  output  ERR_W  number of mismatching vectors in the last sweep.
- first_fail_vec  output  8  {a,b} of the first mismatch.
- first_fail_valid  output  1  first_fail_vec holds a captured value.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; vector counter 0; golden delay line cleared. Reset mid-sweep aborts immediately; no partial results survive.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - dut_a/dut_b=0.
  - start=1 → clear err_count, first_fail_valid, first_fail_vec and the vector counter; go to RUN.
- RUN:
  - Vector v (8 bits) is registered onto dut_a=v[7:4], dut_b=v[3:0].
  - v starts at 0 and increments by 1 per cycle.
  - After v=255 is presented, go to DRAIN if DUT_LAT>0, else go directly to DONE.
  - No wrap-around: exactly 256 vectors per sweep.
- Golden and compare:
  - golden = {1'b0,a}+{1'b0,b}, 5 bits, delayed DUT_LAT cycles alongside its vector tag.
  - dut_o is compared in the cycle its vector's golden emerges from the delay line. With DUT_LAT=0, the compare happens in the same cycle the vector is on dut_a/dut_b.
  - Any bit difference is a mismatch: err_count increments by 1 that cycle.
  - On the first mismatch of the sweep, capture first_fail_vec=tag and set first_fail_valid=1. Later mismatches never overwrite the capture.
- DRAIN: dut_a/dut_b=0; compares continue for exactly DUT_LAT cycles, then go to DONE.
- DONE:
  - done=1; pass=(err_count==0).
  - err_count, first_fail_vec and first_fail_valid hold their values.
  - start=1 → restart as from IDLE. done drops on the same edge RUN is entered.
- start:
  - Ignored in RUN and DRAIN.
  - start and abort together: abort wins.
  - Multi-cycle start in IDLE launches only one sweep; a new sweep needs start sampled in IDLE or DONE.
- abort: in RUN or DRAIN → IDLE next edge. Results are cleared, done=0, pass=0. Ignored in IDLE and DONE.
- Timing: start sampled at edge t0 → vector 0 visible after t0. done rises at edge t0+256+DUT_LAT.
- busy/done/pass are registered and glitch-free; pass is 0 outside DONE.

Test Plan:
- Correct combinational DUT, DUT_LAT=0, pulse start → done after 256 cycles; err_count=0, pass=1, first_fail_valid=0.
- DUT with O[4] stuck-at-0 → err_count=120, pass=0, first_fail_vec=8'h1F (a=1, b=15), first_fail_valid=1.
- DUT with O[0] stuck-at-1 → err_count=128, first_fail_vec=8'h00.
- DUT_LAT=2 with a correctly registered 2-stage adder → done at t0+258, err_count=0; the same DUT with DUT_LAT=0 reports err_count>0.
- Assert abort when v=100, then start again → busy=0 and done=0 after abort; the second sweep completes with fresh results (err_count from the second sweep only).
- Drop rst_n mid-RUN (v≈50) → all outputs 0 immediately, state IDLE; start after release → full 256-vector sweep.
